// File: rtl/io_pkg.sv
// Shared board-I/O constants: button bit positions and channel counts,
// plus the auto-repeat phase type used by the input conditioner.
package io_pkg;

    localparam int N_BTN = 5;
    localparam int N_SW  = 16;

    localparam int BTN_U = 4;
    localparam int BTN_D = 3;
    localparam int BTN_L = 2;
    localparam int BTN_R = 1;
    localparam int BTN_C = 0;

    typedef enum logic {
        PH_FIRST    = 1'b0,
        PH_PERIODIC = 1'b1
    } rep_phase_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchroniser chain, debounce counter and stable flop,
// with registered one-cycle strobes on each accepted rising/falling change.
module debounce_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    // Shift the raw pad level through the synchroniser flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], din};
    end

    // Accept a new value only after it has differed from the stable level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                rise  <= s;
                fall  <= ~s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw buttons and switches into clean levels, press/release
// strobes, a switch-changed strobe and auto-repeat pulses for held buttons.
module input_conditioner
    import io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] but_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_changed
);

    localparam int HW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .din   (but_raw[i]),
            .level (btn_level[i]),
            .rise  (btn_press[i]),
            .fall  (btn_release[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .din   (sw_raw[i]),
            .level (sw_level[i]),
            .rise  (sw_rise[i]),
            .fall  (sw_fall[i])
        );
    end

    // OR of the already-registered per-bit strobes, so the pulse lines up
    // with the cycle sw_level takes its new value and never stretches.
    assign sw_changed = |(sw_rise | sw_fall);

    if (REPEAT_DELAY == 0) begin : g_no_repeat
        assign btn_repeat = '0;
    end else begin : g_repeat
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            logic [HW-1:0] hc;
            logic [HW-1:0] target;
            rep_phase_t    phase;
            logic          rep_q;

            assign target = (phase == PH_FIRST) ? HW'(REPEAT_DELAY) : HW'(REPEAT_PERIOD);

            // Hold counter: idle at 0 while released, wraps to 0 on each repeat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hc    <= '0;
                    phase <= PH_FIRST;
                    rep_q <= 1'b0;
                end else if (!btn_level[i]) begin
                    hc    <= '0;
                    phase <= PH_FIRST;
                    rep_q <= 1'b0;
                end else if (hc == target) begin
                    hc    <= '0;
                    phase <= PH_PERIODIC;
                    rep_q <= 1'b1;
                end else begin
                    hc    <= hc + HW'(1);
                    rep_q <= 1'b0;
                end
            end

            // A wrap landing on the release edge is masked by the falling level,
            // so release and repeat never appear together.
            assign btn_repeat[i] = rep_q & btn_level[i];
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: the stimulus side runs a reference model per edge and
// queues the expected outputs; a monitor pops and compares every cycle.
module tb_input_conditioner;
    import io_pkg::*;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int NCH  = N_BTN + N_SW;

    typedef struct packed {
        logic [N_BTN-1:0] lvl;
        logic [N_BTN-1:0] prs;
        logic [N_BTN-1:0] rel;
        logic [N_BTN-1:0] rpt;
        logic [N_SW-1:0]  sw;
        logic             chg;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] but_raw = '0;
    logic [N_SW-1:0]  sw_raw = '0;
    logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [N_SW-1:0]  sw_level;
    logic             sw_changed;

    int   vectors = 0;
    int   miscompares = 0;
    obs_t exp_q[$];

    // Reference model state: raw samples still in flight, accepted level,
    // length of the current disagreeing run, and edge index of each press.
    bit smp [NCH][SYNC];
    bit stb [NCH];
    int run [NCH];
    int press_edge [N_BTN];
    int edge_n = 0;

    input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .but_raw     (but_raw),
        .sw_raw      (sw_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .sw_level    (sw_level),
        .sw_changed  (sw_changed)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge with the given inputs and queue
    // what the DUT must show right after that edge.
    task automatic model_step(input bit r, input logic [N_BTN-1:0] b, input logic [N_SW-1:0] s);
        obs_t e;
        bit   old [NCH];
        bit   raw, sv;
        int   d;
        e = '0;
        edge_n++;
        for (int c = 0; c < NCH; c++) begin
            old[c] = stb[c];
            if (c < N_BTN) raw = b[c];
            else           raw = s[c - N_BTN];
            if (r) begin
                for (int k = 0; k < SYNC; k++) smp[c][k] = 1'b0;
                stb[c] = 1'b0;
                run[c] = 0;
            end else begin
                sv = smp[c][SYNC-1];
                for (int k = SYNC - 1; k > 0; k--) smp[c][k] = smp[c][k-1];
                smp[c][0] = raw;
                if (sv != stb[c]) begin
                    run[c]++;
                    if (run[c] == DB) begin
                        stb[c] = sv;
                        run[c] = 0;
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
        if (!r) begin
            for (int i = 0; i < N_BTN; i++) begin
                e.lvl[i] = stb[i];
                e.prs[i] = stb[i] && !old[i];
                e.rel[i] = !stb[i] && old[i];
                if (e.prs[i]) press_edge[i] = edge_n;
                if (stb[i] && old[i]) begin
                    d = edge_n - press_edge[i];
                    e.rpt[i] = (d >= RD + 1) && (((d - RD - 1) % (RP + 1)) == 0);
                end
            end
            for (int j = 0; j < N_SW; j++) begin
                e.sw[j] = stb[N_BTN + j];
                if (stb[N_BTN + j] != old[N_BTN + j]) e.chg = 1'b1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input logic [N_BTN-1:0] b, input logic [N_SW-1:0] s);
        @(negedge clk);
        rst     = r;
        but_raw = b;
        sw_raw  = s;
        model_step(r, b, s);
    endtask

    task automatic hold(input int n);
        repeat (n) cyc(1'b0, but_raw, sw_raw);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0);
    endtask

    // Raise reset between edges and require every output to clear without a clock.
    task automatic async_rst_check();
        obs_t got;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        got = {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_changed};
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL async_reset @%0t outputs got %h required 0", $time, got);
        end
    endtask

    // Monitor: compare the DUT against the next queued expectation each cycle.
    always @(posedge clk) begin : monitor
        obs_t got, e;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_changed};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL obs @%0t lvl %b/%b prs %b/%b rel %b/%b rpt %b/%b sw %h/%h chg %b/%b (got/required)",
                         $time, got.lvl, e.lvl, got.prs, e.prs, got.rel, e.rel,
                         got.rpt, e.rpt, got.sw, e.sw, got.chg, e.chg);
            end
        end
    end

    initial begin : stimulus
        logic [N_BTN-1:0] nb;
        logic [N_SW-1:0]  ns;

        repeat (3) cyc(1'b1, '0, '0);
        idle(10);

        // Clean press on butc
        cyc(1'b0, 5'b00001, '0);
        hold(12);
        idle(12);

        // Bouncing butu, then held
        cyc(1'b0, 5'b10000, '0);
        cyc(1'b0, 5'b00000, '0);
        cyc(1'b0, 5'b10000, '0);
        cyc(1'b0, 5'b00000, '0);
        cyc(1'b0, 5'b10000, '0);
        hold(15);
        idle(12);

        // Auto-repeat on butc, then release
        cyc(1'b0, 5'b00001, '0);
        hold(66);
        idle(15);

        // Switches 0x8001, then a 3-cycle glitch low on bit 0
        cyc(1'b0, '0, 16'h8001);
        hold(10);
        repeat (3) cyc(1'b0, '0, 16'h8000);
        cyc(1'b0, '0, 16'h8001);
        hold(10);
        idle(12);

        // Reset while butc is mid-repeat and butd is mid-debounce
        cyc(1'b0, 5'b00001, '0);
        hold(35);
        repeat (4) cyc(1'b0, 5'b01001, '0);
        async_rst_check();
        repeat (2) cyc(1'b1, 5'b01001, '0);
        cyc(1'b0, 5'b01001, '0);
        hold(20);
        idle(12);

        // Simultaneous butl + butr
        cyc(1'b0, 5'b00110, '0);
        hold(40);
        idle(12);

        // Random phase: slow button flips, faster switch flips, rare resets
        for (int n = 0; n < 3000; n++) begin
            nb = but_raw;
            ns = sw_raw;
            for (int i = 0; i < N_BTN; i++) if ($urandom_range(31) == 0) nb[i] = ~nb[i];
            for (int j = 0; j < N_SW; j++)  if ($urandom_range(7) == 0)  ns[j] = ~ns[j];
            cyc(($urandom_range(499) == 0), nb, ns);
        end
        idle(12);

        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue left %0d required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
